// File: rtl/e203_exu_alu_oitf.sv
// e203_exu_alu_oitf: outstanding-instruction tracking FIFO for ALU-class
// long write-back. It allocates an itag at dispatch and stores rd/pc per entry.
// The oldest entry is presented for write-back and freed on oitf_ret_ena.
// Combinational RAW/WAW matches are computed against the dispatching instruction.
// Optional macro E203_OITF_CNT_EN adds a registered occupancy count output oitf_cnt.
module e203_exu_alu_oitf #(
    parameter int DEPTH       = 4,
    parameter int ITAG_WIDTH  = 2,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dis_ena,
    output logic                   dis_ready,
    output logic [ITAG_WIDTH-1:0]  dis_ptr,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    output logic                   oitf_ret_rdwen,
    output logic [PC_SIZE-1:0]     oitf_ret_pc,
`ifdef E203_OITF_CNT_EN
    output logic [ITAG_WIDTH:0]    oitf_cnt,
`endif
    output logic                   oitf_empty
);

    localparam logic [ITAG_WIDTH-1:0] LAST = ITAG_WIDTH'(DEPTH - 1);

    logic [ITAG_WIDTH-1:0]  alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
    logic                   alc_flg_q, alc_flg_d, ret_flg_q, ret_flg_d;
    logic                   vld_q   [DEPTH];
    logic                   vld_d   [DEPTH];
    logic                   rdwen_q [DEPTH];
    logic                   rdwen_d [DEPTH];
    logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic [RFIDX_WIDTH-1:0] rdidx_d [DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [DEPTH];
    logic [PC_SIZE-1:0]     pc_d    [DEPTH];

    logic full, empty, alc_fire, ret_fire;
    logic hit_rs1, hit_rs2, hit_rd;

    assign empty     = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
    assign full      = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
    assign dis_ready = ~full;
    assign dis_ptr   = alc_ptr_q;
    assign alc_fire  = dis_ena & ~full;
    // Retire is gated on the registered empty flag, so an entry allocated this
    // cycle cannot be retired until the next cycle.
    assign ret_fire  = oitf_ret_ena & ~empty;

    assign oitf_empty     = empty;
    assign oitf_ret_ptr   = ret_ptr_q;
    assign oitf_ret_rdidx = rdidx_q[ret_ptr_q];
    assign oitf_ret_rdwen = rdwen_q[ret_ptr_q];
    assign oitf_ret_pc    = pc_q[ret_ptr_q];

    // Next-state: pointer/flag advance, entry allocate and valid clear on retire
    always_comb begin
        alc_ptr_d = alc_ptr_q;
        alc_flg_d = alc_flg_q;
        ret_ptr_d = ret_ptr_q;
        ret_flg_d = ret_flg_q;
        vld_d     = vld_q;
        rdwen_d   = rdwen_q;
        rdidx_d   = rdidx_q;
        pc_d      = pc_q;
        if (alc_fire) begin
            vld_d[alc_ptr_q]   = 1'b1;
            rdwen_d[alc_ptr_q] = disp_i_rdwen;
            rdidx_d[alc_ptr_q] = disp_i_rdidx;
            pc_d[alc_ptr_q]    = disp_i_pc;
            if (alc_ptr_q == LAST) begin
                alc_ptr_d = '0;
                alc_flg_d = ~alc_flg_q;
            end else begin
                alc_ptr_d = alc_ptr_q + ITAG_WIDTH'(1);
            end
        end
        // The retiring slot cannot equal the allocating slot: that would need
        // the FIFO to be both empty and full.
        if (ret_fire) begin
            vld_d[ret_ptr_q] = 1'b0;
            if (ret_ptr_q == LAST) begin
                ret_ptr_d = '0;
                ret_flg_d = ~ret_flg_q;
            end else begin
                ret_ptr_d = ret_ptr_q + ITAG_WIDTH'(1);
            end
        end
    end

    // State registers; async reset drops every outstanding entry immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr_q <= '0;
            alc_flg_q <= 1'b0;
            ret_ptr_q <= '0;
            ret_flg_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]   <= 1'b0;
                rdwen_q[i] <= 1'b0;
                rdidx_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            alc_ptr_q <= alc_ptr_d;
            alc_flg_q <= alc_flg_d;
            ret_ptr_q <= ret_ptr_d;
            ret_flg_q <= ret_flg_d;
            vld_q     <= vld_d;
            rdwen_q   <= rdwen_d;
            rdidx_q   <= rdidx_d;
            pc_q      <= pc_d;
        end
    end

    // Hazard search over registered entries only (state before this cycle's updates)
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] & rdwen_q[i]) begin
                if (rdidx_q[i] == disp_i_rs1idx) hit_rs1 = 1'b1;
                if (rdidx_q[i] == disp_i_rs2idx) hit_rs2 = 1'b1;
                if (rdidx_q[i] == disp_i_rdidx)  hit_rd  = 1'b1;
            end
        end
    end

    // x0 is hardwired, so index 0 never creates a dependency
    assign oitfrd_match_disprs1 = disp_i_rs1en & (disp_i_rs1idx != '0) & hit_rs1;
    assign oitfrd_match_disprs2 = disp_i_rs2en & (disp_i_rs2idx != '0) & hit_rs2;
    assign oitfrd_match_disprd  = disp_i_rdwen & (disp_i_rdidx  != '0) & hit_rd;

`ifdef E203_OITF_CNT_EN
    logic [ITAG_WIDTH:0] cnt_q, cnt_d;

    // Occupancy count: moves only when exactly one of allocate/retire fires
    always_comb begin
        cnt_d = cnt_q;
        if (alc_fire & ~ret_fire)      cnt_d = cnt_q + (ITAG_WIDTH+1)'(1);
        else if (ret_fire & ~alc_fire) cnt_d = cnt_q - (ITAG_WIDTH+1)'(1);
    end

    // Occupancy count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign oitf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_e203_exu_alu_oitf.sv
// Directed self-checking bench for e203_exu_alu_oitf (default parameters, DEPTH=4).
module tb_e203_exu_alu_oitf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dis_ena = 1'b0;
    logic        dis_ready;
    logic [1:0]  dis_ptr;
    logic        disp_i_rdwen = 1'b0;
    logic [4:0]  disp_i_rdidx = '0;
    logic [31:0] disp_i_pc = '0;
    logic        disp_i_rs1en = 1'b0;
    logic        disp_i_rs2en = 1'b0;
    logic [4:0]  disp_i_rs1idx = '0;
    logic [4:0]  disp_i_rs2idx = '0;
    logic        oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
    logic        oitf_ret_ena = 1'b0;
    logic [1:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen;
    logic [31:0] oitf_ret_pc;
`ifdef E203_OITF_CNT_EN
    logic [2:0]  oitf_cnt;
`endif
    logic        oitf_empty;

    int pass_cnt = 0;
    int total_cnt = 0;

    e203_exu_alu_oitf dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dis_ena              (dis_ena),
        .dis_ready            (dis_ready),
        .dis_ptr              (dis_ptr),
        .disp_i_rdwen         (disp_i_rdwen),
        .disp_i_rdidx         (disp_i_rdidx),
        .disp_i_pc            (disp_i_pc),
        .disp_i_rs1en         (disp_i_rs1en),
        .disp_i_rs2en         (disp_i_rs2en),
        .disp_i_rs1idx        (disp_i_rs1idx),
        .disp_i_rs2idx        (disp_i_rs2idx),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .oitf_ret_ena         (oitf_ret_ena),
        .oitf_ret_ptr         (oitf_ret_ptr),
        .oitf_ret_rdidx       (oitf_ret_rdidx),
        .oitf_ret_rdwen       (oitf_ret_rdwen),
        .oitf_ret_pc          (oitf_ret_pc),
`ifdef E203_OITF_CNT_EN
        .oitf_cnt             (oitf_cnt),
`endif
        .oitf_empty           (oitf_empty)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dis_ena = 0; oitf_ret_ena = 0;
        disp_i_rdwen = 0; disp_i_rdidx = 0; disp_i_pc = 0;
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs1idx = 0; disp_i_rs2idx = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        tick();
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] pc);
        dis_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = rd; disp_i_pc = pc;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        total_cnt++;
        if ({oitf_empty, dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen} !== {1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 1'b0})
            $display("FAIL reset_flags got empty=%b rdy=%b dptr=%0d rptr=%0d rdidx=%0d rdwen=%b", oitf_empty, dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen);
        else pass_cnt++;
        total_cnt++;
        if (oitf_ret_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", oitf_ret_pc);
        else pass_cnt++;
        rst_n = 1;
        tick();
        tick();
        total_cnt++;
        if ({oitf_empty, dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd} !== {1'b1, 1'b1, 2'd0, 3'b000})
            $display("FAIL reset_idle got empty=%b rdy=%b dptr=%0d m=%b%b%b", oitf_empty, dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        alloc(5'd5, 32'h100);
        disp_i_rs1en = 1; disp_i_rs1idx = 5;
        disp_i_rs2en = 1; disp_i_rs2idx = 6;
        disp_i_rdwen = 1; disp_i_rdidx = 5;
        #1;
        total_cnt++;
        if (oitfrd_match_disprs1 !== 1'b1) $display("FAIL raw_rs1 got %b want 1", oitfrd_match_disprs1);
        else pass_cnt++;
        total_cnt++;
        if (oitfrd_match_disprs2 !== 1'b0) $display("FAIL raw_rs2_miss got %b want 0", oitfrd_match_disprs2);
        else pass_cnt++;
        total_cnt++;
        if (oitfrd_match_disprd !== 1'b1) $display("FAIL waw_rd got %b want 1", oitfrd_match_disprd);
        else pass_cnt++;
        total_cnt++;
        if ({oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_pc} !== {1'b0, 2'd0, 5'd5, 1'b1, 32'h100})
            $display("FAIL ret_head got empty=%b ptr=%0d rd=%0d wen=%b pc=%h want 0/0/5/1/100", oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_pc);
        else pass_cnt++;
        // rs2 now targets 5 but its enable is off
        disp_i_rs2en = 0; disp_i_rs2idx = 5;
        #1;
        total_cnt++;
        if (oitfrd_match_disprs2 !== 1'b0) $display("FAIL rs2_disabled got %b want 0", oitfrd_match_disprs2);
        else pass_cnt++;
        oitf_ret_ena = 1;
        tick();
        oitf_ret_ena = 0;
        #1;
        total_cnt++;
        if ({oitf_empty, oitfrd_match_disprs1, oitfrd_match_disprd, oitf_ret_ptr} !== {1'b1, 1'b0, 1'b0, 2'd1})
            $display("FAIL retire_single got empty=%b m1=%b mrd=%b rptr=%0d want 1/0/0/1", oitf_empty, oitfrd_match_disprs1, oitfrd_match_disprd, oitf_ret_ptr);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_full();
        logic [1:0] exp_ptr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_ptr = 2'(i);
            total_cnt++;
            if (dis_ptr !== exp_ptr || dis_ready !== 1'b1) $display("FAIL fill_ptr%0d got ptr=%0d rdy=%b want %0d/1", i, dis_ptr, dis_ready, exp_ptr);
            else pass_cnt++;
            alloc(5'(i + 1), 32'h200 + 32'(i * 4));
        end
        total_cnt++;
        if ({dis_ready, oitf_empty, dis_ptr} !== {1'b0, 1'b0, 2'd0}) $display("FAIL full_flags got rdy=%b empty=%b dptr=%0d want 0/0/0", dis_ready, oitf_empty, dis_ptr);
        else pass_cnt++;
        // Allocate while full must be dropped
        alloc(5'd9, 32'h999);
        disp_i_rs1en = 1; disp_i_rs1idx = 9;
        disp_i_rs2en = 1; disp_i_rs2idx = 3;
        #1;
        total_cnt++;
        if ({oitfrd_match_disprs1, oitfrd_match_disprs2, dis_ready, oitf_ret_rdidx, oitf_ret_pc} !== {1'b0, 1'b1, 1'b0, 5'd1, 32'h200})
            $display("FAIL full_ignore got m1=%b m2=%b rdy=%b rd=%0d pc=%h want 0/1/0/1/200", oitfrd_match_disprs1, oitfrd_match_disprs2, dis_ready, oitf_ret_rdidx, oitf_ret_pc);
        else pass_cnt++;
        idle_inputs();
        // Full plus retire plus allocate: retire only, no pass-through
        dis_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 7; disp_i_pc = 32'h700;
        oitf_ret_ena = 1;
        #1;
        total_cnt++;
        if (dis_ready !== 1'b0) $display("FAIL full_ret_same_cycle got rdy=%b want 0", dis_ready);
        else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++;
        if ({dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx} !== {1'b1, 2'd0, 2'd1, 5'd2})
            $display("FAIL after_full_ret got rdy=%b dptr=%0d rptr=%0d rd=%0d want 1/0/1/2", dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx);
        else pass_cnt++;
        disp_i_rs1en = 1; disp_i_rs1idx = 1;
        disp_i_rs2en = 1; disp_i_rs2idx = 7;
        #1;
        total_cnt++;
        if ({oitfrd_match_disprs1, oitfrd_match_disprs2} !== 2'b00) $display("FAIL retired_no_match got m1=%b m2=%b want 00", oitfrd_match_disprs1, oitfrd_match_disprs2);
        else pass_cnt++;
        idle_inputs();
        alloc(5'd7, 32'h700);
        total_cnt++;
        if ({dis_ready, dis_ptr} !== {1'b0, 2'd1}) $display("FAIL wrap_alloc got rdy=%b dptr=%0d want 0/1", dis_ready, dis_ptr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc(5'd10, 32'h1000);
        alloc(5'd11, 32'h1004);
        dis_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 12; disp_i_pc = 32'h1008;
        oitf_ret_ena = 1;
        tick();
        idle_inputs();
        total_cnt++;
        if ({oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_pc, dis_ptr, oitf_empty, dis_ready} !== {2'd1, 5'd11, 32'h1004, 2'd3, 1'b0, 1'b1})
            $display("FAIL b2b got rptr=%0d rd=%0d pc=%h dptr=%0d empty=%b rdy=%b want 1/11/1004/3/0/1", oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_pc, dis_ptr, oitf_empty, dis_ready);
        else pass_cnt++;
`ifdef E203_OITF_CNT_EN
        total_cnt++;
        if (oitf_cnt !== 3'd2) $display("FAIL b2b_cnt got %0d want 2", oitf_cnt);
        else pass_cnt++;
`endif
        oitf_ret_ena = 1;
        tick();
        total_cnt++;
        if ({oitf_empty, oitf_ret_ptr, oitf_ret_rdidx} !== {1'b0, 2'd2, 5'd12}) $display("FAIL b2b_drain1 got empty=%b rptr=%0d rd=%0d want 0/2/12", oitf_empty, oitf_ret_ptr, oitf_ret_rdidx);
        else pass_cnt++;
        tick();
        oitf_ret_ena = 0;
        total_cnt++;
        if ({oitf_empty, oitf_ret_ptr} !== {1'b1, 2'd3}) $display("FAIL b2b_drain2 got empty=%b rptr=%0d want 1/3", oitf_empty, oitf_ret_ptr);
        else pass_cnt++;
    endtask

    task automatic test_empty_and_zero();
        do_reset();
        oitf_ret_ena = 1;
        tick();
        total_cnt++;
        if ({oitf_empty, dis_ready, oitf_ret_ptr, dis_ptr} !== {1'b1, 1'b1, 2'd0, 2'd0}) $display("FAIL ret_while_empty got empty=%b rdy=%b rptr=%0d dptr=%0d want 1/1/0/0", oitf_empty, dis_ready, oitf_ret_ptr, dis_ptr);
        else pass_cnt++;
        // Empty + allocate + retire: allocate only
        dis_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 0; disp_i_pc = 32'h40;
        tick();
        idle_inputs();
        total_cnt++;
        if ({oitf_empty, oitf_ret_ptr, dis_ptr, oitf_ret_pc} !== {1'b0, 2'd0, 2'd1, 32'h40}) $display("FAIL empty_alc_ret got empty=%b rptr=%0d dptr=%0d pc=%h want 0/0/1/40", oitf_empty, oitf_ret_ptr, dis_ptr, oitf_ret_pc);
        else pass_cnt++;
        disp_i_rs1en = 1; disp_i_rs1idx = 0;
        disp_i_rdwen = 1; disp_i_rdidx = 0;
        #1;
        total_cnt++;
        if ({oitfrd_match_disprs1, oitfrd_match_disprd} !== 2'b00) $display("FAIL x0_match got m1=%b mrd=%b want 00", oitfrd_match_disprs1, oitfrd_match_disprd);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc(5'd3, 32'h30);
        alloc(5'd4, 32'h34);
        alloc(5'd6, 32'h38);
        total_cnt++;
        if ({oitf_empty, dis_ptr} !== {1'b0, 2'd3}) $display("FAIL pre_async got empty=%b dptr=%0d want 0/3", oitf_empty, dis_ptr);
        else pass_cnt++;
        #2;
        rst_n = 0;
        #1;
        total_cnt++;
        if ({oitf_empty, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, dis_ready} !== {1'b1, 2'd0, 2'd0, 5'd0, 1'b1})
            $display("FAIL async_reset got empty=%b dptr=%0d rptr=%0d rd=%0d rdy=%b want 1/0/0/0/1", oitf_empty, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, dis_ready);
        else pass_cnt++;
        total_cnt++;
        if (oitf_ret_pc !== 32'h0) $display("FAIL async_reset_pc got %h want 0", oitf_ret_pc);
        else pass_cnt++;
        rst_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_empty_and_zero();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
